// File: rtl/hdmi_infoframe_pkg.sv
// Shared types and helpers for the InfoFrame scheduler: FSM states, packet
// layout (3 header bytes, 4 sub-packets of 7 bytes) and PB byte extraction.
package hdmi_infoframe_pkg;

  localparam int NUM_SRC_DEFAULT = 4;
  localparam int SUB_CNT         = 4;
  localparam int SUB_BYTES       = 7;
  localparam int PB_COUNT        = SUB_CNT * SUB_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } sched_state_t;

  typedef logic [7:0]                    pkt_byte_t;
  typedef logic [23:0]                   pkt_header_t;
  typedef logic [8*SUB_BYTES-1:0]        pkt_subpkt_t;
  typedef pkt_subpkt_t [SUB_CNT-1:0]     pkt_sub_t;

  // PB(7k+j) lives at sub[k][8j+7:8j], which flattens to bits [8n+7:8n].
  function automatic pkt_byte_t get_pb(input pkt_sub_t sub, input int unsigned n);
    logic [8*PB_COUNT-1:0] flat;
    flat = sub;
    return pkt_byte_t'(flat >> (8 * n));
  endfunction

endpackage

// File: rtl/infoframe_checksum.sv
// Combinational InfoFrame checksum: the byte that makes HB0..HB2 + PB0..PB27
// sum to zero mod 256 (PB0 itself is excluded from the input sum).
module infoframe_checksum
  import hdmi_infoframe_pkg::*;
(
  input  pkt_header_t header,
  input  pkt_sub_t    sub,
  output pkt_byte_t   checksum
);

  pkt_byte_t sum;

  always_comb begin
    sum = header[7:0] + header[15:8] + header[23:16];
    for (int unsigned n = 1; n < PB_COUNT; n++) begin
      sum = sum + get_pb(sub, n);
    end
    checksum = 8'h00 - sum;
  end

endmodule

// File: rtl/infoframe_scheduler.sv
// Once-per-frame InfoFrame scheduler: round-robin over pending sources, loads
// the chosen packet (optionally with checksum) and offers it until taken.
module infoframe_scheduler
  import hdmi_infoframe_pkg::*;
#(
  parameter  int NUM_SRC = NUM_SRC_DEFAULT,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                     clk_pixel,
  input  logic                     reset_n,
  input  logic                     frame_start,
  input  logic                     packet_enable,
  input  logic [NUM_SRC-1:0]       src_enable,
  input  logic [NUM_SRC-1:0]       src_checksum_en,
  input  logic [NUM_SRC-1:0][23:0] src_header,
  input  pkt_sub_t [NUM_SRC-1:0]   src_sub,
  output logic                     pkt_valid,
  output logic [23:0]              pkt_header,
  output pkt_sub_t                 pkt_sub,
  output logic [SRC_W-1:0]         pkt_src,
  output logic [7:0]               missed_count
);

  localparam logic [SRC_W:0]   NUM_SRC_W1 = (SRC_W+1)'(NUM_SRC);
  localparam logic [SRC_W-1:0] LAST_SRC   = SRC_W'(NUM_SRC - 1);

  sched_state_t       state_reg;
  logic [NUM_SRC-1:0] pending_reg;
  logic [NUM_SRC-1:0] pending_next;
  logic [NUM_SRC-1:0] clr_mask;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] rr_rot;
  logic [SRC_W-1:0]   rr_ptr_reg;
  logic [SRC_W-1:0]   sel_reg;
  logic [SRC_W-1:0]   rr_off;
  logic [SRC_W-1:0]   rr_pick;
  logic [SRC_W:0]     pick_sum;
  logic               rr_found;
  logic               accept;
  logic               overrun;
  pkt_header_t        mux_header;
  pkt_sub_t           mux_sub;
  pkt_sub_t           load_sub;
  pkt_byte_t          mux_checksum;

  assign accept = (state_reg == ST_READY) && packet_enable;

  // Accept clears first and frame_start sets second, so a coinciding frame re-arms.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pending
      assign clr_mask[gi]     = accept && (sel_reg == SRC_W'(gi));
      assign pending_next[gi] = src_enable[gi] & ((pending_reg[gi] & ~clr_mask[gi]) | frame_start);
      assign eligible[gi]     = pending_reg[gi] & src_enable[gi];
    end
  endgenerate

  assign overrun = frame_start && (|(pending_reg & ~clr_mask & src_enable));

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      pending_reg  <= '0;
      missed_count <= '0;
    end else begin
      pending_reg <= pending_next;
      if (overrun && (missed_count != 8'hFF)) begin
        missed_count <= missed_count + 8'd1;
      end
    end
  end

  // Rotate so bit 0 is rr_ptr, take the first set bit, then rotate back.
  assign rr_rot = NUM_SRC'({eligible, eligible} >> rr_ptr_reg);

  always_comb begin
    rr_found = 1'b0;
    rr_off   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!rr_found && rr_rot[k]) begin
        rr_found = 1'b1;
        rr_off   = SRC_W'(k);
      end
    end
    pick_sum = {1'b0, rr_ptr_reg} + {1'b0, rr_off};
    if (pick_sum >= NUM_SRC_W1) begin
      pick_sum = pick_sum - NUM_SRC_W1;
    end
    rr_pick = pick_sum[SRC_W-1:0];
  end

  assign mux_header = src_header[sel_reg];
  assign mux_sub    = src_sub[sel_reg];

  infoframe_checksum u_checksum (
    .header   (mux_header),
    .sub      (mux_sub),
    .checksum (mux_checksum)
  );

  always_comb begin
    load_sub = mux_sub;
    if (src_checksum_en[sel_reg]) begin
      load_sub[0][7:0] = mux_checksum;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      rr_ptr_reg <= '0;
      sel_reg    <= '0;
      pkt_valid  <= 1'b0;
      pkt_header <= '0;
      pkt_sub    <= '0;
      pkt_src    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (rr_found) begin
            sel_reg   <= rr_pick;
            state_reg <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          pkt_header <= mux_header;
          pkt_sub    <= load_sub;
          pkt_src    <= sel_reg;
          pkt_valid  <= 1'b1;
          state_reg  <= ST_READY;
        end
        ST_READY: begin
          if (packet_enable) begin
            rr_ptr_reg <= (sel_reg == LAST_SRC) ? '0 : sel_reg + 1'b1;
            pkt_valid  <= 1'b0;
            state_reg  <= ST_IDLE;
          end else if (!src_enable[sel_reg]) begin
            pkt_valid <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          pkt_valid <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_infoframe_scheduler.sv
// Randomized self-checking bench for infoframe_scheduler against a simple
// pending-set / round-robin / checksum reference model.
module tb_infoframe_scheduler;

  localparam int N = 4;

  logic                clk_pixel = 1'b0;
  logic                reset_n = 1'b0;
  logic                frame_start = 1'b0;
  logic                packet_enable = 1'b0;
  logic [N-1:0]        src_enable = '0;
  logic [N-1:0]        src_checksum_en = '0;
  logic [N-1:0][23:0]  src_header = '0;
  logic [N-1:0][3:0][55:0] src_sub = '0;
  logic                pkt_valid;
  logic [23:0]         pkt_header;
  logic [3:0][55:0]    pkt_sub;
  logic [1:0]          pkt_src;
  logic [7:0]          missed_count;

  int n_checks = 0;
  int n_pass = 0;

  logic [N-1:0] m_pending = '0;
  int m_rr = 0;
  int m_missed = 0;

  infoframe_scheduler #(.NUM_SRC(N)) dut (
    .clk_pixel       (clk_pixel),
    .reset_n         (reset_n),
    .frame_start     (frame_start),
    .packet_enable   (packet_enable),
    .src_enable      (src_enable),
    .src_checksum_en (src_checksum_en),
    .src_header      (src_header),
    .src_sub         (src_sub),
    .pkt_valid       (pkt_valid),
    .pkt_header      (pkt_header),
    .pkt_sub         (pkt_sub),
    .pkt_src         (pkt_src),
    .missed_count    (missed_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_checksum(input logic [23:0] hdr, input logic [223:0] body);
    int s;
    s = int'(hdr[7:0]) + int'(hdr[15:8]) + int'(hdr[23:16]);
    for (int n = 1; n < 28; n++) s += int'(body[8*n +: 8]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  function automatic logic [223:0] ref_sub(input int s);
    logic [223:0] body;
    body = src_sub[s];
    if (src_checksum_en[s]) body[7:0] = ref_checksum(src_header[s], body);
    return body;
  endfunction

  function automatic int ref_next();
    for (int k = 0; k < N; k++) if (m_pending[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  task automatic model_frame();
    if (m_pending != '0 && m_missed < 255) m_missed++;
    m_pending = (m_pending | src_enable) & src_enable;
  endtask

  task automatic model_accept(input int s);
    m_pending[s] = 1'b0;
    m_rr = (s + 1) % N;
  endtask

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk_pixel);
    reset_n = 1'b1;
    m_pending = '0; m_rr = 0; m_missed = 0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    model_frame();
    @(negedge clk_pixel);
    frame_start = 1'b0;
  endtask

  task automatic pulse_accept();
    packet_enable = 1'b1;
    @(negedge clk_pixel);
    packet_enable = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (pkt_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk_pixel);
    end
  endtask

  task automatic randomize_sources();
    for (int s = 0; s < N; s++) begin
      src_header[s] = 24'($urandom);
      for (int k = 0; k < 4; k++) src_sub[s][k] = 56'({$urandom, $urandom});
    end
    src_checksum_en = 4'($urandom);
  endtask

  // Offer check: waits for pkt_valid, then compares against the model's pick.
  task automatic check_offer(input string tag, output int exp);
    bit ok;
    exp = ref_next();
    wait_valid(10, ok);
    n_checks++;
    if (!ok) $display("FAIL %s_valid: pkt_valid got %0b want 1 (timeout)", tag, pkt_valid); else n_pass++;
    n_checks++;
    if (exp < 0 || pkt_src !== 2'(exp)) $display("FAIL %s_src: got %0d want %0d", tag, pkt_src, exp); else n_pass++;
    if (exp >= 0) begin
      n_checks++;
      if (pkt_header !== src_header[exp]) $display("FAIL %s_hdr: got %h want %h", tag, pkt_header, src_header[exp]); else n_pass++;
      n_checks++;
      if (pkt_sub !== ref_sub(exp)) $display("FAIL %s_sub: got %h want %h", tag, pkt_sub, ref_sub(exp)); else n_pass++;
    end
    $display("offer %s: src=%0d hdr=%h pb0=%h", tag, pkt_src, pkt_header, pkt_sub[0][7:0]);
  endtask

  task automatic accept_offer(input int exp);
    pulse_accept();
    if (exp >= 0) model_accept(exp);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit saw;
    reset_n = 1'b0;
    repeat (2) @(negedge clk_pixel);
    n_checks++; if (pkt_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", pkt_valid); else n_pass++;
    n_checks++; if (pkt_header !== 24'h0) $display("FAIL rst_hdr: got %h want 0", pkt_header); else n_pass++;
    n_checks++; if (pkt_sub !== '0) $display("FAIL rst_sub: got %h want 0", pkt_sub); else n_pass++;
    n_checks++; if (pkt_src !== 2'd0) $display("FAIL rst_src: got %0d want 0", pkt_src); else n_pass++;
    n_checks++; if (missed_count !== 8'd0) $display("FAIL rst_missed: got %0d want 0", missed_count); else n_pass++;
    reset_n = 1'b1;
    m_pending = '0; m_rr = 0; m_missed = 0;
    src_enable = '1;
    saw = 1'b0;
    repeat (10) begin @(negedge clk_pixel); if (pkt_valid !== 1'b0) saw = 1'b1; end
    n_checks++; if (saw) $display("FAIL rst_no_offer: pkt_valid seen before first frame_start, want none"); else n_pass++;
    src_enable = '0;
    $display("test_reset done");
  endtask

  task automatic test_checksum_vector();
    src_header[0] = 24'h050181;
    src_sub[0] = '0;
    src_sub[0][0] = 56'h0002_01C4_5DD8_00;
    src_sub[0][1] = 56'h12;
    src_checksum_en = 4'b0001;
    src_enable = 4'b0001;
    pulse_frame();
    n_checks++; if (pkt_valid !== 1'b0) $display("FAIL cks_lat1: got %0b want 0", pkt_valid); else n_pass++;
    @(negedge clk_pixel);
    n_checks++; if (pkt_valid !== 1'b0) $display("FAIL cks_lat2: got %0b want 0", pkt_valid); else n_pass++;
    @(negedge clk_pixel);
    n_checks++; if (pkt_valid !== 1'b1) $display("FAIL cks_lat3: got %0b want 1", pkt_valid); else n_pass++;
    n_checks++; if (pkt_sub[0][7:0] !== 8'h6B) $display("FAIL cks_pb0: got %h want 6b", pkt_sub[0][7:0]); else n_pass++;
    n_checks++; if (pkt_sub !== ref_sub(0)) $display("FAIL cks_sub: got %h want %h", pkt_sub, ref_sub(0)); else n_pass++;
    n_checks++; if (pkt_header !== 24'h050181) $display("FAIL cks_hdr: got %h want 050181", pkt_header); else n_pass++;
    $display("checksum vector: pb0=%h", pkt_sub[0][7:0]);
    accept_offer(0);
    n_checks++; if (pkt_valid !== 1'b0) $display("FAIL cks_drop: got %0b want 0", pkt_valid); else n_pass++;
    src_enable = '0;
  endtask

  task automatic test_round_robin_all();
    int exp;
    bit stable, saw;
    do_reset();
    randomize_sources();
    src_enable = 4'b1111;
    pulse_frame();
    for (int i = 0; i < N; i++) begin
      check_offer("rr_all", exp);
      stable = 1'b1;
      repeat (31) begin
        @(negedge clk_pixel);
        if (pkt_valid !== 1'b1 || pkt_src !== 2'(exp) || pkt_sub !== ref_sub(exp)) stable = 1'b0;
      end
      n_checks++; if (!stable) $display("FAIL rr_all_stable: outputs changed in READY, want stable for src %0d", exp); else n_pass++;
      accept_offer(exp);
    end
    saw = 1'b0;
    repeat (10) begin @(negedge clk_pixel); if (pkt_valid !== 1'b0) saw = 1'b1; end
    n_checks++; if (saw) $display("FAIL rr_all_idle: pkt_valid got 1 after drain, want 0"); else n_pass++;
    n_checks++; if (missed_count !== 8'(m_missed)) $display("FAIL rr_all_missed: got %0d want %0d", missed_count, m_missed); else n_pass++;
    src_enable = '0;
  endtask

  task automatic test_rr_order();
    int exp;
    randomize_sources();
    src_enable = 4'b0010;
    pulse_frame();
    check_offer("rr_prep", exp);
    accept_offer(exp);
    src_enable = 4'b1001;
    pulse_frame();
    check_offer("rr_order_a", exp);
    accept_offer(exp);
    check_offer("rr_order_b", exp);
    accept_offer(exp);
    src_enable = '0;
  endtask

  task automatic test_abort();
    int exp;
    bit saw;
    randomize_sources();
    src_enable = 4'b0100;
    pulse_frame();
    check_offer("abort", exp);
    src_enable = 4'b0000;
    m_pending = m_pending & src_enable;
    @(negedge clk_pixel);
    n_checks++; if (pkt_valid !== 1'b0) $display("FAIL abort_drop: got %0b want 0", pkt_valid); else n_pass++;
    src_enable = 4'b0100;
    saw = 1'b0;
    repeat (10) begin @(negedge clk_pixel); if (pkt_valid !== 1'b0) saw = 1'b1; end
    n_checks++; if (saw) $display("FAIL abort_pending: src 2 re-offered, want pending cleared"); else n_pass++;
    src_enable = '0;
  endtask

  task automatic test_coincide();
    int exp;
    randomize_sources();
    src_enable = 4'b0010;
    pulse_frame();
    check_offer("coin_first", exp);
    frame_start = 1'b1;
    packet_enable = 1'b1;
    model_accept(exp);
    model_frame();
    @(negedge clk_pixel);
    frame_start = 1'b0;
    packet_enable = 1'b0;
    n_checks++; if (pkt_valid !== 1'b0) $display("FAIL coin_idle: got %0b want 0", pkt_valid); else n_pass++;
    check_offer("coin_rearm", exp);
    n_checks++; if (missed_count !== 8'(m_missed)) $display("FAIL coin_missed: got %0d want %0d", missed_count, m_missed); else n_pass++;
    accept_offer(exp);
    src_enable = '0;
  endtask

  task automatic test_random();
    int exp;
    bit stable, saw;
    for (int r = 0; r < 6; r++) begin
      randomize_sources();
      src_enable = 4'($urandom_range(1, 15));
      pulse_frame();
      while (m_pending != '0) begin
        check_offer("rand", exp);
        stable = 1'b1;
        repeat ($urandom_range(0, 5)) begin
          @(negedge clk_pixel);
          if (pkt_valid !== 1'b1 || pkt_src !== 2'(exp)) stable = 1'b0;
        end
        n_checks++; if (!stable) $display("FAIL rand_hold: offer of src %0d not held", exp); else n_pass++;
        accept_offer(exp);
      end
      saw = 1'b0;
      repeat (4) begin @(negedge clk_pixel); if (pkt_valid !== 1'b0) saw = 1'b1; end
      n_checks++; if (saw) $display("FAIL rand_idle: pkt_valid got 1 after drain, want 0"); else n_pass++;
    end
    n_checks++; if (missed_count !== 8'(m_missed)) $display("FAIL rand_missed: got %0d want %0d", missed_count, m_missed); else n_pass++;
    src_enable = '0;
  endtask

  task automatic test_missed();
    do_reset();
    src_enable = 4'b1111;
    for (int f = 0; f < 3; f++) begin
      pulse_frame();
      repeat (3) @(negedge clk_pixel);
    end
    n_checks++; if (missed_count !== 8'(m_missed)) $display("FAIL missed_3: got %0d want %0d", missed_count, m_missed); else n_pass++;
    $display("missed after 3 frames: %0d", missed_count);
    for (int f = 0; f < 300; f++) begin
      pulse_frame();
      repeat (3) @(negedge clk_pixel);
    end
    n_checks++; if (missed_count !== 8'(m_missed)) $display("FAIL missed_sat: got %0d want %0d", missed_count, m_missed); else n_pass++;
    $display("missed after 303 frames: %0d", missed_count);
  endtask

  task automatic test_reset_mid_ready();
    bit saw;
    n_checks++; if (pkt_valid !== 1'b1) $display("FAIL mid_pre_valid: got %0b want 1", pkt_valid); else n_pass++;
    @(posedge clk_pixel);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (pkt_valid !== 1'b0) $display("FAIL mid_valid: got %0b want 0", pkt_valid); else n_pass++;
    n_checks++; if (pkt_header !== 24'h0) $display("FAIL mid_hdr: got %h want 0", pkt_header); else n_pass++;
    n_checks++; if (pkt_sub !== '0) $display("FAIL mid_sub: got %h want 0", pkt_sub); else n_pass++;
    n_checks++; if (pkt_src !== 2'd0) $display("FAIL mid_src: got %0d want 0", pkt_src); else n_pass++;
    n_checks++; if (missed_count !== 8'd0) $display("FAIL mid_missed: got %0d want 0", missed_count); else n_pass++;
    @(negedge clk_pixel);
    reset_n = 1'b1;
    m_pending = '0; m_rr = 0; m_missed = 0;
    saw = 1'b0;
    repeat (10) begin @(negedge clk_pixel); if (pkt_valid !== 1'b0) saw = 1'b1; end
    n_checks++; if (saw) $display("FAIL mid_no_offer: offer after reset without frame_start"); else n_pass++;
    src_enable = '0;
    $display("test_reset_mid_ready done");
  endtask

  initial begin
    @(negedge clk_pixel);
    test_reset();
    test_checksum_vector();
    test_round_robin_all();
    test_rr_order();
    test_abort();
    test_coincide();
    test_random();
    test_missed();
    test_reset_mid_ready();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/infoframe_scheduler.md
INFOFRAME_SCHEDULER -- requirements
Module: infoframe_scheduler

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, meaning the number of InfoFrame sources, legal range 2..8.
REQ-002 SHALL have port clk_pixel, input, 1 bit: the single clock (pixel clock).
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port frame_start, input, 1 bit: one-cycle pulse, once per video frame.
REQ-005 SHALL have port packet_enable, input, 1 bit: one-cycle pulse; the packet assembler takes the offered packet in this cycle.
REQ-006 SHALL have port src_enable, input, NUM_SRC bits: per-source enable for once-per-frame transmission.
REQ-007 SHALL have port src_checksum_en, input, NUM_SRC bits: 1 means PB0 is replaced by the computed checksum.
REQ-008 SHALL have port src_header, input, NUM_SRC x 24 bits: HB2..HB0 per source, with HB0 in bits [7:0].
REQ-009 SHALL have port src_sub, input, NUM_SRC x 4 x 56 bits, with PB(7k+j) in sub[k] bits [8j+7:8j].
REQ-010 SHALL have port pkt_valid, output, 1 bit: a packet is offered.
REQ-011 SHALL have port pkt_header, output, 24 bits, and port pkt_sub, output, 4 x 56 bits: the offered packet.
REQ-012 SHALL have port pkt_src, output, clog2(NUM_SRC) bits: index of the offered source.
REQ-013 SHALL have port missed_count, output, 8 bits: saturating count of frames in which a pending source was not sent.

Function
REQ-014 SHALL keep one pending bit per source; frame_start sets pending[i] for every i with src_enable[i]=1.
REQ-015 SHALL clear pending[i] immediately when src_enable[i]=0.
REQ-016 SHALL implement states IDLE, LOAD, READY.
REQ-017 In IDLE, when any pending bit is set, SHALL round-robin select the first pending index at or after rr_ptr, store it as sel, and go to LOAD.
REQ-018 In LOAD, SHALL register src_header[sel] and src_sub[sel] into the output registers, with PB0 substituted when src_checksum_en[sel]=1, then go to READY.
REQ-019 Latency from a pending bit being set in IDLE to pkt_valid=1 SHALL be exactly 2 cycles.
REQ-020 pkt_valid SHALL equal 1 only in READY; outputs SHALL stay stable throughout READY.
REQ-021 In READY with packet_enable=1, SHALL clear pending[sel], set rr_ptr to sel+1 mod NUM_SRC, and go to IDLE.
REQ-022 In READY with packet_enable=0 and src_enable[sel]=0, SHALL abort to IDLE with pkt_valid=0 in the next cycle.
REQ-023 packet_enable SHALL be ignored in IDLE and LOAD.
REQ-024 Checksum SHALL be PB0 = (0x100 - ((HB0+HB1+HB2+PB1+...+PB27) mod 256)) mod 256, using 8-bit wraparound arithmetic.
REQ-025 When frame_start and packet_enable coincide on the same source, the clear SHALL happen first and the set second, so the bit ends set.
REQ-026 frame_start while pending[i]=1 (and not cleared that cycle) SHALL increment missed_count by 1 per frame, saturating at 255.
REQ-027 Multiple overrun sources in one frame_start SHALL count as one.

Reset
REQ-028 While reset_n=0, SHALL asynchronously force: state IDLE, pending 0, rr_ptr 0, sel 0, pkt_valid 0, pkt_header 0, pkt_sub 0, pkt_src 0, missed_count 0.
REQ-029 Reset asserted mid-READY SHALL drop pkt_valid within the same cycle.
REQ-030 Nothing SHALL be offered until the first frame_start after reset release.

Structure
REQ-031 Package hdmi_infoframe_pkg SHALL hold: the state enum, the NUM_SRC default, the packet byte/sub layout typedefs, and the function that extracts PB bytes.
REQ-032 Combinational sub-module infoframe_checksum SHALL take header and sub and output an 8-bit checksum; it SHALL be instantiated once, on the sel mux output.

Verification
REQ-033 Scenario: src0 header 0x050181, PB1..PB7 = D8 5D C4 01 02 00 12, rest 0, checksum_en=1, frame_start -> pkt_valid at +2 cycles, sub[0][7:0]=0x6B.
REQ-034 Scenario: all 4 sources enabled, frame_start, packet_enable pulsed every 32 cycles -> pkt_src sequence 0,1,2,3, then pkt_valid=0.
REQ-035 Scenario: rr_ptr=2, sources 0 and 3 pending -> order 3 then 0.
REQ-036 Scenario: 4 sources enabled, no packet_enable, 3 frame_start pulses -> missed_count=2; 300 frames -> missed_count=255.
REQ-037 Scenario: in READY, src_enable[sel] dropped with no packet_enable -> pkt_valid=0 next cycle, pending[sel]=0.
REQ-038 Scenario: frame_start and packet_enable in the same cycle for src1 -> pending[1]=1 afterwards, missed_count unchanged; reset_n low mid-READY -> all outputs 0 immediately.
